// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard scoreboard: per-register result countdowns plus a
// MUL/DIV occupancy counter, producing stall/bubble controls for IF and ID.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] RS1,
    input  logic [REG_ADDR_W-1:0] RS2,
    input  logic                  RS1_used,
    input  logic                  RS2_used,
    input  logic [REG_ADDR_W-1:0] ID_Rd,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemRead,
    input  logic                  ID_MulDiv,
    input  logic                  ID_valid,
    input  logic                  flush_i,
    output logic                  STALL,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  No_Op,
    output logic                  busy_o
);

    localparam int NREGS   = 2 ** REG_ADDR_W;
    localparam int MAX_LAT = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] LOAD_VAL   = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] MULDIV_VAL = CNT_W'(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    logic [CNT_W-1:0] r_cnt [NREGS];
    logic [CNT_W-1:0] r_mdCnt;

    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_str;
    logic             w_stall;
    logic             w_issue;
    logic [CNT_W-1:0] w_setVal;
    logic             w_anyCnt;

    assign w_raw1  = RS1_used & (r_cnt[RS1] != CNT_ZERO);
    assign w_raw2  = RS2_used & (r_cnt[RS2] != CNT_ZERO);
    assign w_waw   = ID_RegWrite & (ID_Rd != '0) & (r_cnt[ID_Rd] != CNT_ZERO);
    assign w_str   = ID_MulDiv & (r_mdCnt != CNT_ZERO);

    // A flushed instruction is squashed, so it can neither stall nor issue.
    assign w_stall = ID_valid & ~flush_i & (w_raw1 | w_raw2 | w_waw | w_str);
    assign w_issue = ID_valid & ~flush_i & ~w_stall;

    // Load wins if decode ever asserts both load and mul/div.
    assign w_setVal = ID_MemRead ? LOAD_VAL : (ID_MulDiv ? MULDIV_VAL : CNT_ZERO);

    always_comb begin
        w_anyCnt = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            w_anyCnt = w_anyCnt | (r_cnt[r] != CNT_ZERO);
        end
    end

    assign STALL       = w_stall;
    assign No_Op       = w_stall;
    assign PC_write    = ~w_stall;
    assign IF_ID_write = ~w_stall;
    assign busy_o      = w_anyCnt | (r_mdCnt != CNT_ZERO);

    // Entry 0 is x0 and never becomes pending; a new issue overrides the countdown.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= CNT_ZERO;
            end
        end else begin
            r_cnt[0] <= CNT_ZERO;
            for (int r = 1; r < NREGS; r++) begin
                if (w_issue && ID_RegWrite && (ID_Rd == REG_ADDR_W'(r))) begin
                    r_cnt[r] <= w_setVal;
                end else if (r_cnt[r] != CNT_ZERO) begin
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mdCnt <= CNT_ZERO;
        end else if (w_issue && ID_MulDiv && !ID_MemRead) begin
            r_mdCnt <= MULDIV_VAL;
        end else if (r_mdCnt != CNT_ZERO) begin
            r_mdCnt <= r_mdCnt - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit: one instance with a 1-cycle
// load latency and one with a 3-cycle load latency, selected per vector.
module tb_hazard_scoreboard_unit;

    typedef struct {
        string name;
        bit    sel;
        bit    expStall;
        bit    expBusy;
    } expect_t;

    logic       clk;
    logic       rstN;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1Used;
    logic       rs2Used;
    logic [4:0] rd;
    logic       regWrite;
    logic       memRead;
    logic       mulDiv;
    logic       idValid;
    logic       flush;
    logic       sel;

    logic       valid0;
    logic       valid1;
    logic       stall0, pcw0, ifw0, noop0, busy0;
    logic       stall1, pcw1, ifw1, noop1, busy1;

    expect_t    expQ[$];
    int         vecCount;
    int         missCount;

    assign valid0 = idValid & ~sel;
    assign valid1 = idValid & sel;

    hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .MULDIV_LAT(4)) dut0 (
        .clk_i(clk), .rst_i(rstN),
        .RS1(rs1), .RS2(rs2), .RS1_used(rs1Used), .RS2_used(rs2Used),
        .ID_Rd(rd), .ID_RegWrite(regWrite), .ID_MemRead(memRead),
        .ID_MulDiv(mulDiv), .ID_valid(valid0), .flush_i(flush),
        .STALL(stall0), .PC_write(pcw0), .IF_ID_write(ifw0),
        .No_Op(noop0), .busy_o(busy0)
    );

    hazard_scoreboard_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .MULDIV_LAT(4)) dut1 (
        .clk_i(clk), .rst_i(rstN),
        .RS1(rs1), .RS2(rs2), .RS1_used(rs1Used), .RS2_used(rs2Used),
        .ID_Rd(rd), .ID_RegWrite(regWrite), .ID_MemRead(memRead),
        .ID_MulDiv(mulDiv), .ID_valid(valid1), .flush_i(flush),
        .STALL(stall1), .PC_write(pcw1), .IF_ID_write(ifw1),
        .No_Op(noop1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID-stage vector just after the rising edge and queue its expectation.
    task automatic applyStimulus(input string name, input bit s, input bit rstLvl,
                                 input bit v, input int a1, input bit u1,
                                 input int a2, input bit u2, input int d,
                                 input bit w, input bit ld, input bit md,
                                 input bit fl, input bit eStall, input bit eBusy);
        expect_t e;
        @(posedge clk);
        #1;
        rstN     = rstLvl;
        sel      = s;
        idValid  = v;
        rs1      = 5'(a1);
        rs1Used  = u1;
        rs2      = 5'(a2);
        rs2Used  = u2;
        rd       = 5'(d);
        regWrite = w;
        memRead  = ld;
        mulDiv   = md;
        flush    = fl;
        e.name     = name;
        e.sel      = s;
        e.expStall = eStall;
        e.expBusy  = eBusy;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        logic aStall, aPcw, aIfw, aNoop, aBusy;
        aStall = e.sel ? stall1 : stall0;
        aPcw   = e.sel ? pcw1   : pcw0;
        aIfw   = e.sel ? ifw1   : ifw0;
        aNoop  = e.sel ? noop1  : noop0;
        aBusy  = e.sel ? busy1  : busy0;
        vecCount++;
        if (aStall !== e.expStall || aNoop !== e.expStall || aPcw !== ~e.expStall ||
            aIfw !== ~e.expStall || aBusy !== e.expBusy) begin
            missCount++;
            $display("[TB] FAIL %s: got stall=%b noop=%b pcw=%b ifw=%b busy=%b, want stall=%b noop=%b pcw=%b ifw=%b busy=%b",
                     e.name, aStall, aNoop, aPcw, aIfw, aBusy,
                     e.expStall, e.expStall, ~e.expStall, ~e.expStall, e.expBusy);
        end
    endtask

    // Outputs are combinational, so each queued vector is judged mid-cycle.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        vecCount  = 0;
        missCount = 0;
        rstN = 1'b0; sel = 1'b0; idValid = 1'b0; flush = 1'b0;
        rs1 = '0; rs2 = '0; rs1Used = 1'b0; rs2Used = 1'b0;
        rd = '0; regWrite = 1'b0; memRead = 1'b0; mulDiv = 1'b0;

        //              name           sel rst v  rs1 u  rs2 u  rd w ld md fl  stall busy
        applyStimulus("reset_lw",      0, 0, 1,  1, 1,  0, 0,  5, 1, 1, 0, 0,  0, 0);

        // Load-use with LOAD_LAT=1: exactly one bubble.
        applyStimulus("l1_lw_x5",      1, 1, 1,  1, 1,  0, 0,  5, 1, 1, 0, 0,  0, 0);
        applyStimulus("l1_use_stall",  1, 1, 1,  5, 1,  1, 1,  6, 1, 0, 0, 0,  1, 1);
        applyStimulus("l1_use_issue",  1, 1, 1,  5, 1,  1, 1,  6, 1, 0, 0, 0,  0, 0);
        applyStimulus("l1_bubble",     1, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0);

        // Load-use with LOAD_LAT=3: three bubbles, independent op is free.
        applyStimulus("l3_lw_x7",      0, 1, 1,  2, 1,  0, 0,  7, 1, 1, 0, 0,  0, 0);
        applyStimulus("l3_use_s1",     0, 1, 1,  7, 1,  3, 1, 10, 1, 0, 0, 0,  1, 1);
        applyStimulus("l3_use_s2",     0, 1, 1,  7, 1,  3, 1, 10, 1, 0, 0, 0,  1, 1);
        applyStimulus("l3_use_s3",     0, 1, 1,  7, 1,  3, 1, 10, 1, 0, 0, 0,  1, 1);
        applyStimulus("l3_use_issue",  0, 1, 1,  7, 1,  3, 1, 10, 1, 0, 0, 0,  0, 0);
        applyStimulus("l3_lw_x7_b",    0, 1, 1,  2, 1,  0, 0,  7, 1, 1, 0, 0,  0, 0);
        applyStimulus("l3_indep",      0, 1, 1,  1, 1,  2, 1, 11, 1, 0, 0, 0,  0, 1);
        applyStimulus("l3_drain2",     0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 1);
        applyStimulus("l3_drain1",     0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 1);
        applyStimulus("l3_idle",       0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0);

        // Structural hazard on the MUL/DIV unit, then RAW on the mul result.
        applyStimulus("md_mul_x8",     0, 1, 1,  1, 1,  2, 1,  8, 1, 0, 1, 0,  0, 0);
        applyStimulus("md_str_s1",     0, 1, 1,  3, 1,  4, 1,  9, 1, 0, 1, 0,  1, 1);
        applyStimulus("md_str_s2",     0, 1, 1,  3, 1,  4, 1,  9, 1, 0, 1, 0,  1, 1);
        applyStimulus("md_str_s3",     0, 1, 1,  3, 1,  4, 1,  9, 1, 0, 1, 0,  1, 1);
        applyStimulus("md_str_s4",     0, 1, 1,  3, 1,  4, 1,  9, 1, 0, 1, 0,  1, 1);
        applyStimulus("md_str_issue",  0, 1, 1,  3, 1,  4, 1,  9, 1, 0, 1, 0,  0, 0);
        applyStimulus("md_raw_s1",     0, 1, 1,  9, 1,  1, 1, 12, 1, 0, 0, 0,  1, 1);
        applyStimulus("md_raw_s2",     0, 1, 1,  9, 1,  1, 1, 12, 1, 0, 0, 0,  1, 1);
        applyStimulus("md_raw_s3",     0, 1, 1,  9, 1,  1, 1, 12, 1, 0, 0, 0,  1, 1);
        applyStimulus("md_raw_s4",     0, 1, 1,  9, 1,  1, 1, 12, 1, 0, 0, 0,  1, 1);
        applyStimulus("md_raw_issue",  0, 1, 1,  9, 1,  1, 1, 12, 1, 0, 0, 0,  0, 0);

        // WAW: addi x8 behind a pending mul x8.
        applyStimulus("waw_mul_x8",    0, 1, 1,  1, 1,  2, 1,  8, 1, 0, 1, 0,  0, 0);
        applyStimulus("waw_s1",        0, 1, 1,  1, 1,  0, 0,  8, 1, 0, 0, 0,  1, 1);
        applyStimulus("waw_s2",        0, 1, 1,  1, 1,  0, 0,  8, 1, 0, 0, 0,  1, 1);
        applyStimulus("waw_s3",        0, 1, 1,  1, 1,  0, 0,  8, 1, 0, 0, 0,  1, 1);
        applyStimulus("waw_s4",        0, 1, 1,  1, 1,  0, 0,  8, 1, 0, 0, 0,  1, 1);
        applyStimulus("waw_issue",     0, 1, 1,  1, 1,  0, 0,  8, 1, 0, 0, 0,  0, 0);

        // x0 never pending; unused source ignored; flushed load sets nothing.
        applyStimulus("x0_lw",         0, 1, 1,  1, 1,  0, 0,  0, 1, 1, 0, 0,  0, 0);
        applyStimulus("x0_use",        0, 1, 1,  0, 1,  0, 1,  1, 1, 0, 0, 0,  0, 0);
        applyStimulus("unused_lw_x9",  0, 1, 1,  1, 1,  0, 0,  9, 1, 1, 0, 0,  0, 0);
        applyStimulus("unused_rs2",    0, 1, 1,  1, 1,  9, 0, 13, 1, 0, 0, 0,  0, 1);
        applyStimulus("flush_dep",     0, 1, 1,  9, 1,  0, 0, 14, 1, 1, 0, 1,  0, 1);
        applyStimulus("flush_noset",   0, 1, 1, 14, 1,  0, 0, 15, 1, 0, 0, 0,  0, 1);
        applyStimulus("flush_idle",    0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0);

        // Reset mid-mul with the occupancy counter at 2.
        applyStimulus("rst_mul_x8",    0, 1, 1,  1, 1,  2, 1,  8, 1, 0, 1, 0,  0, 0);
        applyStimulus("rst_busy4",     0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 1);
        applyStimulus("rst_busy3",     0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 1);
        applyStimulus("rst_held_mul",  0, 0, 1,  3, 1,  4, 1, 10, 1, 0, 1, 0,  0, 0);
        applyStimulus("rst_rel_mul",   0, 1, 1,  3, 1,  4, 1, 10, 1, 0, 1, 0,  0, 0);

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL queue_drain: %0d entries left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
